// File: rtl/clock_pkg.sv
// Shared types, limits and BCD increment helpers for the clock-set controller.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t ones;
    } bcd_pair_t;

    localparam bcd_t       MAX_HOUR_T          = 4'd2;
    localparam bcd_t       MAX_HOUR_ONES_AT_T2 = 4'd3;
    localparam bcd_t       MAX_MIN_T           = 4'd5;
    localparam logic [5:0] MAX_SEC             = 6'd59;

    // Hour 00..23 with wrap to 00.
    function automatic bcd_pair_t inc_hour(input bcd_pair_t h);
        bcd_pair_t r;
        if (h.tens == MAX_HOUR_T && h.ones == MAX_HOUR_ONES_AT_T2) begin
            r = '0;
        end else if (h.ones == 4'd9) begin
            r.tens = h.tens + 4'd1;
            r.ones = 4'd0;
        end else begin
            r.tens = h.tens;
            r.ones = h.ones + 4'd1;
        end
        return r;
    endfunction

    // Minute 00..59 with wrap to 00; the carry is detected separately.
    function automatic bcd_pair_t inc_min(input bcd_pair_t m);
        bcd_pair_t r;
        if (m.ones == 4'd9) begin
            r.ones = 4'd0;
            r.tens = (m.tens == MAX_MIN_T) ? 4'd0 : m.tens + 4'd1;
        end else begin
            r.tens = m.tens;
            r.ones = m.ones + 4'd1;
        end
        return r;
    endfunction

    function automatic logic min_at_max(input bcd_pair_t m);
        return (m.tens == MAX_MIN_T) && (m.ones == 4'd9);
    endfunction

endpackage

// File: rtl/clock_set_controller_btn_edge_sync.sv
// Button synchronizer plus registered rising-edge detector: one pulse per press.
module btn_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   pulse_q;

    always_ff @(posedge Clk) begin
        if (!reset) begin
            sync_q  <= '0;
            last_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            last_q  <= sync_q[SYNC_STAGES-1];
            pulse_q <= sync_q[SYNC_STAGES-1] & ~last_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/clock_set_controller.sv
// HH:MM timekeeping with RUN/SET_HOUR/SET_MIN editing; all display controls registered.
// Optional macro CLOCK_SET_BLINK_EN enables blinking of the digits under edit.
module clock_set_controller
    import clock_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RESET_H10   = 1,
    parameter int RESET_H1    = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       blink_tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output bcd_t       h10,
    output bcd_t       h1,
    output bcd_t       m10,
    output bcd_t       m1,
    output logic [3:0] digit_blank,
    output logic       colon_on,
    output logic       setting
);

    logic mode_p;
    logic inc_p;

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_mode_sync (
        .Clk   (Clk),
        .reset (reset),
        .din   (btn_mode),
        .pulse (mode_p)
    );

    btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_inc_sync (
        .Clk   (Clk),
        .reset (reset),
        .din   (btn_inc),
        .pulse (inc_p)
    );

    state_t     state_q, state_d;
    bcd_pair_t  hour_q, hour_d;
    bcd_pair_t  min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       colon_q, colon_d;
    logic       setting_q, setting_d;

    // A mode pulse always wins over inc; in RUN a coincident tick still lands first.
    always_comb begin
        state_d = state_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        unique case (state_q)
            RUN: begin
                if (tick_1hz) begin
                    if (sec_q == MAX_SEC) begin
                        sec_d = 6'd0;
                        min_d = inc_min(min_q);
                        if (min_at_max(min_q)) begin
                            hour_d = inc_hour(hour_q);
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end
                if (mode_p) begin
                    state_d = SET_HOUR;
                end
            end
            SET_HOUR: begin
                if (mode_p) begin
                    state_d = SET_MIN;
                end else if (inc_p) begin
                    hour_d = inc_hour(hour_q);
                end
            end
            SET_MIN: begin
                if (mode_p) begin
                    state_d = RUN;
                    sec_d   = 6'd0;
                end else if (inc_p) begin
                    min_d = inc_min(min_q);
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        colon_d   = (state_d == RUN) ? ~sec_d[0] : 1'b1;
        setting_d = (state_d != RUN);
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state_q   <= RUN;
            hour_q    <= {bcd_t'(RESET_H10), bcd_t'(RESET_H1)};
            min_q     <= '0;
            sec_q     <= 6'd0;
            colon_q   <= 1'b1;
            setting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            colon_q   <= colon_d;
            setting_q <= setting_d;
        end
    end

`ifdef CLOCK_SET_BLINK_EN
    logic       blink_q, blink_d;
    logic [3:0] blank_q, blank_d;

    // Any button action restarts the blink dark-free so the new value is visible.
    always_comb begin
        blink_d = blink_q;
        if (mode_p || inc_p) begin
            blink_d = 1'b0;
        end else if (blink_tick) begin
            blink_d = ~blink_q;
        end
        unique case (state_d)
            SET_HOUR: blank_d = {blink_d, blink_d, 2'b00};
            SET_MIN:  blank_d = {2'b00, blink_d, blink_d};
            default:  blank_d = 4'b0000;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!reset) begin
            blink_q <= 1'b0;
            blank_q <= 4'b0000;
        end else begin
            blink_q <= blink_d;
            blank_q <= blank_d;
        end
    end

    assign digit_blank = blank_q;
`else
    logic unused_blink_tick;
    assign unused_blink_tick = blink_tick;
    assign digit_blank       = 4'b0000;
`endif

    assign h10      = hour_q.tens;
    assign h1       = hour_q.ones;
    assign m10      = min_q.tens;
    assign m1       = min_q.ones;
    assign colon_on = colon_q;
    assign setting  = setting_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed and random stimulus against a seconds/minutes/hours reference model of the clock.
module tb_clock_set_controller;

    localparam int SS  = 2;
    localparam int RH10 = 1;
    localparam int RH1  = 2;

    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       blink_tick = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic [3:0] h10, h1, m10, m1;
    logic [3:0] digit_blank;
    logic       colon_on;
    logic       setting;

    always #5 Clk = ~Clk;

    clock_set_controller #(
        .SYNC_STAGES (SS),
        .RESET_H10   (RH10),
        .RESET_H1    (RH1)
    ) dut (
        .Clk         (Clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .blink_tick  (blink_tick),
        .btn_mode    (btn_mode),
        .btn_inc     (btn_inc),
        .h10         (h10),
        .h1          (h1),
        .m10         (m10),
        .m1          (m1),
        .digit_blank (digit_blank),
        .colon_on    (colon_on),
        .setting     (setting)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: plain integer time of day plus mode number (0 run, 1 hour, 2 minute).
    int m_hh, m_mm, m_ss, m_mode;
    bit m_blink;
    bit hist_m[0:SS+2];
    bit hist_i[0:SS+2];

    task automatic model_step(input bit r, input bit t, input bit bt, input bit bm, input bit bi);
        bit mp, ip;
        if (!r) begin
            m_hh = RH10 * 10 + RH1;
            m_mm = 0;
            m_ss = 0;
            m_mode = 0;
            m_blink = 1'b0;
            for (int i = 0; i <= SS + 2; i++) begin
                hist_m[i] = 1'b0;
                hist_i[i] = 1'b0;
            end
        end else begin
            for (int i = SS + 2; i > 0; i--) begin
                hist_m[i] = hist_m[i-1];
                hist_i[i] = hist_i[i-1];
            end
            hist_m[0] = bm;
            hist_i[0] = bi;
            // A press acts SS+2 edges after the first edge that samples it high.
            mp = hist_m[SS+1] && !hist_m[SS+2];
            ip = hist_i[SS+1] && !hist_i[SS+2];
            case (m_mode)
                0: begin
                    if (t) begin
                        m_ss++;
                        if (m_ss == 60) begin
                            m_ss = 0;
                            m_mm++;
                            if (m_mm == 60) begin
                                m_mm = 0;
                                m_hh = (m_hh + 1) % 24;
                            end
                        end
                    end
                    if (mp) m_mode = 1;
                end
                1: begin
                    if (mp) m_mode = 2;
                    else if (ip) m_hh = (m_hh + 1) % 24;
                end
                default: begin
                    if (mp) begin
                        m_mode = 0;
                        m_ss = 0;
                    end else if (ip) begin
                        m_mm = (m_mm + 1) % 60;
                    end
                end
            endcase
            if (mp || ip) m_blink = 1'b0;
            else if (bt) m_blink = ~m_blink;
        end
    endtask

    function automatic logic [15:0] exp_digits();
        return {4'(m_hh / 10), 4'(m_hh % 10), 4'(m_mm / 10), 4'(m_mm % 10)};
    endfunction

    function automatic logic [3:0] exp_blank();
`ifdef CLOCK_SET_BLINK_EN
        if (m_mode == 1) return {m_blink, m_blink, 2'b00};
        if (m_mode == 2) return {2'b00, m_blink, m_blink};
`endif
        return 4'b0000;
    endfunction

    function automatic logic exp_colon();
        return (m_mode == 0) ? (m_ss % 2 == 0) : 1'b1;
    endfunction

    task automatic step(input bit r, input bit t, input bit bt, input bit bm, input bit bi);
        reset = r;
        tick_1hz = t;
        blink_tick = bt;
        btn_mode = bm;
        btn_inc = bi;
        @(posedge Clk);
        model_step(r, t, bt, bm, bi);
        #1;
        check_val("digits", 32'({h10, h1, m10, m1}), 32'(exp_digits()));
        check_val("blank", 32'(digit_blank), 32'(exp_blank()));
        check_val("colon", 32'(colon_on), 32'(exp_colon()));
        check_val("setting", 32'(setting), 32'(m_mode != 0));
    endtask

    task automatic press(input bit bm, input bit bi, input int n);
        for (int k = 0; k < n; k++) begin
            step(1, 0, 0, bm, bi);
            step(1, 0, 0, bm, bi);
            for (int j = 0; j < 5; j++) step(1, 0, 0, 0, 0);
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) step(1, 1, 0, 0, 0);
    endtask

    // Raise mode so that its update edge coincides with a tick.
    task automatic mode_with_tick();
        for (int k = 0; k < SS + 1; k++) step(1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, 0);
    endtask

    initial begin
        bit rb, tb, bb, mb, ib;
        logic [3:0] blank_on;
`ifdef CLOCK_SET_BLINK_EN
        blank_on = 4'b0011;
`else
        blank_on = 4'b0000;
`endif

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check_val("rst_digits", 32'({h10, h1, m10, m1}), 32'h1200);
        check_val("rst_colon", 32'(colon_on), 32'd1);
        check_val("rst_setting", 32'(setting), 32'd0);
        check_val("rst_blank", 32'(digit_blank), 32'd0);

        ticks(60);
        check_val("sixty_ticks", 32'({h10, h1, m10, m1}), 32'h1201);
        check_val("sixty_colon", 32'(colon_on), 32'd1);

        step(0, 0, 0, 0, 0);
        press(1, 0, 1);
        press(0, 1, 14);
        check_val("hour_wrap", 32'({h10, h1, m10, m1}), 32'h0200);
        press(1, 0, 1);
        press(0, 1, 61);
        check_val("min_wrap", 32'({h10, h1, m10, m1}), 32'h0201);
        press(1, 0, 1);
        check_val("back_run", 32'(setting), 32'd0);
        check_val("back_colon", 32'(colon_on), 32'd1);

        press(1, 0, 1);
        press(0, 1, 21);
        press(1, 0, 1);
        press(0, 1, 58);
        press(1, 0, 1);
        check_val("preload", 32'({h10, h1, m10, m1}), 32'h2359);
        ticks(59);
        check_val("pre_roll", 32'({h10, h1, m10, m1}), 32'h2359);
        ticks(1);
        check_val("rollover", 32'({h10, h1, m10, m1}), 32'h0000);

        press(1, 0, 1);
        ticks(100);
        check_val("frozen", 32'({h10, h1, m10, m1}), 32'h0000);
        press(1, 1, 1);
        check_val("mode_wins", 32'({h10, h1, m10, m1}), 32'h0000);
        check_val("mode_wins_set", 32'(setting), 32'd1);

        step(1, 0, 1, 0, 0);
        check_val("blink_on", 32'(digit_blank), 32'(blank_on));
        step(1, 0, 1, 0, 0);
        check_val("blink_off", 32'(digit_blank), 32'd0);
        step(1, 0, 1, 0, 0);
        press(0, 1, 1);
        check_val("blink_inc", 32'(digit_blank), 32'd0);
        check_val("blink_min", 32'({h10, h1, m10, m1}), 32'h0001);

        mode_with_tick();
        check_val("setmin_tick_set", 32'(setting), 32'd0);
        check_val("setmin_tick_colon", 32'(colon_on), 32'd1);
        ticks(1);
        check_val("after_tick_colon", 32'(colon_on), 32'd0);

        step(0, 0, 0, 0, 0);
        ticks(59);
        mode_with_tick();
        check_val("run_tick_mode", 32'({h10, h1, m10, m1}), 32'h1201);
        check_val("run_tick_set", 32'(setting), 32'd1);
        press(1, 0, 2);

        for (int k = 1; k <= 1000; k++) begin
            step(1, 0, 0, 1, 0);
            if (k <= SS + 1) check_val("lat_pre", 32'(setting), 32'd0);
            else if (k == SS + 2) check_val("lat_hit", 32'(setting), 32'd1);
        end
        for (int k = 0; k < 5; k++) step(1, 0, 0, 0, 0);
        press(0, 1, 1);
        check_val("held_once", 32'({h10, h1, m10, m1}), 32'h1301);

        mb = 1'b0;
        ib = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) mb = ~mb;
            if ($urandom_range(0, 11) == 0) ib = ~ib;
            tb = ($urandom_range(0, 3) == 0);
            bb = ($urandom_range(0, 7) == 0);
            rb = ($urandom_range(0, 599) != 0);
            step(rb, tb, bb, mb, ib);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Timekeeping and time-set controller for the four-digit clock display. It holds the BCD hour/minute registers and advances them from a 1 Hz strobe. It also runs the RUN → SET_HOUR → SET_MIN mode sequence driven by two push-buttons, and produces the four digit values plus blank/colon controls consumed by the display multiplexer.

## Interface
Parameters:
- SYNC_STAGES, 2, synchronizer flops per button input (≥2)
- RESET_H10, 1, hour-tens value loaded at reset
- RESET_H1, 2, hour-ones value loaded at reset (RESET_H10*10+RESET_H1 ≤ 23)

Ports:
- Clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-low reset
- tick_1hz  input  1  one-Clk-wide strobe, once per second
- blink_tick  input  1  one-Clk-wide strobe, ~4 Hz, blink phase toggle
- btn_mode  input  1  raw mode button, asynchronous, active-high
- btn_inc  input  1  raw increment button, asynchronous, active-high
- h10, h1, m10, m1  output  4 each  BCD digits (h10 0–2, m10 0–5)
- digit_blank  output  4  per-digit blank, bit3=h10 … bit0=m1, 1=dark
- colon_on  output  1  colon segment enable
- setting  output  1  high in SET_HOUR or SET_MIN

## Operation
- Reset (reset=0 at a Clk edge): state RUN, h10/h1 = RESET_H10/RESET_H1, m10=m1=0, seconds=0, blink phase=0, digit_blank=0000, colon_on=1, setting=0, sync/edge flops cleared.
- Each button passes through SYNC_STAGES flops and a rising-edge detector → one-cycle mode_p / inc_p. Level held high yields exactly one pulse.
- States: RUN, SET_HOUR, SET_MIN. mode_p: RUN→SET_HOUR→SET_MIN→RUN.
- RUN: tick_1hz increments the 6-bit binary seconds counter 0..59. At 59 it wraps to 0 and the minute increments. Minute 59→00 carries into the hour. Hour 23→00. Digits are BCD: the ones digit goes 9→0 with a tens carry. inc_p is ignored.
- SET_HOUR: inc_p increments the hour 00..23 and wraps to 00. It does not carry into or out of the minutes. tick_1hz is ignored (time frozen).
- SET_MIN: inc_p increments the minute 00..59 and wraps to 00, with no carry into the hour. tick_1hz is ignored.
- Leaving SET_MIN for RUN clears seconds to 0.
- colon_on: in RUN, equals NOT seconds[0] (on for even seconds). In SET states, constant 1.
- Simultaneous events:
  - mode_p and inc_p in the same cycle: the mode transition wins and inc_p is discarded.
  - RUN with mode_p and tick_1hz together: the tick is applied, then the state moves to SET_HOUR.
  - SET_MIN with mode_p and tick_1hz together: seconds are cleared and the tick is discarded.
- Mid-operation reset returns to RUN with reset time. Any partial edit is lost.

## Timing
- A raw button rise is visible as a register update SYNC_STAGES+2 Clk edges later: sync stages, then the edge flop, then the update.
- tick_1hz is not synchronized; it must be synchronous to Clk. Its digit update appears on the next edge (1-cycle latency).
- All outputs are registered. No combinational path from any input to any output.
- Hour rollover 23:59:59 + tick → 00:00:00 is completed in a single edge.

## Configuration
- CLOCK_SET_BLINK_EN defined:
  - In SET_HOUR, digit_blank[3:2] = blink phase. In SET_MIN, digit_blank[1:0] = blink phase.
  - The blink phase toggles on blink_tick and is forced to 0 on any mode_p or inc_p, so an edited value shows immediately.
  - In RUN, digit_blank = 0000.
- Undefined: digit_blank is tied to 0000. The blink phase flop and blink_tick logic are removed, and blink_tick is left unused.

## Structure
- Shared package clock_pkg:
  - State enum (RUN, SET_HOUR, SET_MIN).
  - Constants MAX_HOUR_T=2, MAX_HOUR_ONES_AT_T2=3, MAX_MIN_T=5, MAX_SEC=59.
  - BCD digit typedef (4-bit).
- Sub-module btn_edge_sync (parameter SYNC_STAGES; ports Clk, reset, din, pulse), instantiated twice.

## Test plan
- Reset, then 60 tick_1hz strobes → digits 1,2,0,1. colon_on toggles each tick and ends at 1.
- Preload via set mode to 23:59, return to RUN, 60 ticks → 00:00 on the 60th tick edge.
- Mode once, 14 inc presses from 12 → hour 02, minutes unchanged. Then mode, 61 inc from 00 → minute 01 with hour still 02. Then mode → RUN, seconds=0, setting=0.
- In SET_HOUR, 100 tick_1hz strobes → digits unchanged. btn_mode and btn_inc rising on the same cycle → state SET_MIN, hour unchanged.
- btn_mode held high 1000 cycles → exactly one transition. Update observed SYNC_STAGES+2 edges after the rise.
- With CLOCK_SET_BLINK_EN: in SET_MIN, blink_tick → digit_blank=0011. Next blink_tick → 0000. inc press → 0000 immediately. Without the macro → 0000 throughout.
